fourier_result_reader: RTL and testbench
========================================

# fourier_result_reader

Result-drain engine for the Fourier core. When the core raises `done`, the block sweeps the core's register read port (`reg_addr` → `reg_data`) from address 0 to NUM_WORDS-1. It captures each word and emits it on a valid/ready stream, marking the final word with `out_last`. It replaces the bench-style "bump address while done" reader with a synthesizable, backpressure-aware master on the other end of the `regAddr`/`regData` interface.

## Interface
- `DATA_W`, 32: width of `reg_data` / `out_data`.
- `ADDR_W`, 32: width of `reg_addr`.
- `NUM_WORDS`, 16: words per result frame; legal range ≥1.
- `READ_LATENCY`, 0: cycles from `reg_addr` change to valid `reg_data`; legal range 0..3. A value of 0 means combinational read.
- `COUNT_W`, 16: width of `frame_count`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `done`, input, 1: level from the core; high means results are stable.
- `reg_addr`, output, ADDR_W: registered read address to the core.
- `reg_data`, input, DATA_W: read data from the core.
- `out_data`, output, DATA_W: captured result word.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: downstream accepts.
- `out_last`, output, 1: current word is address NUM_WORDS-1.
- `busy`, output, 1: high in every state except IDLE.
- `frame_count`, output, COUNT_W: number of completed frames; wraps modulo 2^COUNT_W.
- `err_lost`, output, 1: sticky; `done` dropped mid-sweep.

## Operation
- Reset (`reset`=0, asynchronous) forces the following values:
  - state = IDLE;
  - `reg_addr`, `out_data`, `frame_count` = 0;
  - `out_valid`, `out_last`, `busy`, `err_lost` = 0.
- States and transitions:
  - IDLE: `reg_addr`=0. If `done`=1 at a rising edge, go to WAIT with wait counter cleared.
  - WAIT: the counter runs 0..READ_LATENCY, one step per cycle. At the edge where the counter equals READ_LATENCY:
    - `out_data` ← `reg_data`;
    - `out_last` ← (`reg_addr` == NUM_WORDS-1);
    - `out_valid` ← 1;
    - go to OUT.
  - OUT: hold `out_valid`. On the handshake edge (`out_valid` & `out_ready`), `out_valid` ← 0 and:
    - if not last: `reg_addr` ← `reg_addr`+1, go to WAIT (counter cleared);
    - if last: `reg_addr` ← 0, `frame_count` ← `frame_count`+1, go to FINISH.
  - FINISH: wait for `done`=0, then go to IDLE. This blocks re-triggering on the same `done` level.
- Stream rules:
  - `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a handshake, except on reset.
  - `out_ready` is ignored when `out_valid`=0.
- `reg_addr` is constant throughout WAIT and OUT for a given word. It changes only on the handshake edge.
- `err_lost`:
  - Set at any edge where `done`=0 and state is WAIT or OUT.
  - The sweep continues to completion regardless.
  - Cleared only by reset.
- NUM_WORDS=1: the first word has `out_last`=1.
- `frame_count` at its maximum value wraps to 0 on the next completed frame.
- Reset mid-sweep: the partial frame is dropped, no `out_last` is emitted, and `frame_count` is zeroed.

## Timing
- The `done` edge e0 (in IDLE) moves the block to WAIT; `reg_addr`=0 from reset or the previous frame.
- The first `out_valid` rises after edge e0+READ_LATENCY+1.
- Per-word minimum period is READ_LATENCY+2 cycles with `out_ready` tied high. At READ_LATENCY=0 this is 2 cycles/word, i.e. a full frame of NUM_WORDS=16 takes 32 cycles from e0 to the last handshake.
- Backpressure stretches only the OUT state. No extra cycles are added after `out_ready` returns.
- `busy` falls the edge after `done` is seen low in FINISH. Minimum: the last handshake edge plus 1 cycle.
- `done` held high continuously produces exactly one frame.

## Test plan
- Basic frame:
  - Stimulus: core model returns `reg_data`=0x100+addr, READ_LATENCY=0, `out_ready`=1, `done` pulsed high at cycle 10 and held 40 cycles.
  - Response: 16 words 0x100..0x10F; `out_last` only on 0x10F; `frame_count`=1; `busy` falls after `done` falls.
- Backpressure:
  - Stimulus: `out_ready` toggled 1-of-3 cycles.
  - Response: identical data sequence; `out_data` and `out_last` stable while stalled; `reg_addr` constant during stalls.
- Read latency:
  - Stimulus: READ_LATENCY=2, core model delays data by 2 cycles.
  - Response: correct data; first `out_valid` 3 cycles after the `done` edge; 4-cycle word period with `out_ready`=1.
- Lost done:
  - Stimulus: `done` dropped at word 5.
  - Response: `err_lost`=1 from the next edge; all 16 words still emitted; `err_lost` remains 1 across a second clean frame.
- Reset mid-sweep:
  - Stimulus: `reset`=0 asynchronously at word 7 while `out_valid`=1.
  - Response: all outputs reach their reset values immediately, before the next edge; no `out_last`; a new `done` restarts at address 0.
- Edge cases:
  - NUM_WORDS=1 → one word with `out_last`=1.
  - COUNT_W=2, five frames → `frame_count` sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fourier_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fourier_result_reader_if
// Purpose  : Bundles the Fourier core register read port (reg_addr/reg_data)
//            and the outgoing valid/ready result stream into one interface.
//            The master modport is the result reader; the slave modport is
//            the core plus downstream consumer seen from the other side.
// Revision : 1.0  initial release
// ============================================================================
interface fourier_result_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Register read port towards the core
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;

    // Result stream towards the consumer
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output reg_addr,
        input  reg_data,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  reg_addr,
        output reg_data,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fourier_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : fourier_result_reader
// Purpose  : Result-drain engine for the Fourier core. When the core asserts
//            done, the read port is swept from address 0 to NUM_WORDS-1 and
//            each word is forwarded on a valid/ready stream, the final word
//            flagged with out_last. Completed frames are counted and a sticky
//            flag records done falling while a sweep is in flight.
// Revision : 1.0  initial release
// ============================================================================
module fourier_result_reader #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int NUM_WORDS    = 16,   // words per frame, >= 1
    parameter int READ_LATENCY = 0,    // 0..3 cycles from reg_addr to reg_data
    parameter int COUNT_W      = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset,      // asynchronous, active low
    input  wire logic                   done,
    fourier_result_reader_if.master     bus,
    output logic                        busy,
    output logic [COUNT_W-1:0]          frame_count,
    output logic                        err_lost
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The wait counter only has to reach READ_LATENCY, which is at most 3.
    localparam logic [1:0]        c_LAT       = 2'(READ_LATENCY);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,   // waiting for done
        S_WAIT   = 2'd1,   // letting reg_data settle for the current address
        S_OUT    = 2'd2,   // presenting the captured word downstream
        S_FINISH = 2'd3    // frame complete, waiting for done to drop
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_wait_cnt;
    logic [1:0]          w_wait_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   r_out_data;
    logic [DATA_W-1:0]   w_out_data_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic                r_out_last;
    logic                w_out_last_nxt;
    logic [COUNT_W-1:0]  r_frame_count;
    logic [COUNT_W-1:0]  w_frame_count_nxt;
    logic                r_err_lost;
    logic                w_err_lost_nxt;

    logic                w_handshake;
    logic                w_in_sweep;

    assign w_handshake = r_out_valid & bus.out_ready;
    assign w_in_sweep  = (r_state == S_WAIT) || (r_state == S_OUT);

    // Next-state and next-output decode; every value holds unless a state says otherwise
    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_addr_nxt        = r_addr;
        w_out_data_nxt    = r_out_data;
        w_out_valid_nxt   = r_out_valid;
        w_out_last_nxt    = r_out_last;
        w_frame_count_nxt = r_frame_count;
        // Losing done mid-sweep is only recorded; the sweep itself runs to the end.
        w_err_lost_nxt    = r_err_lost | (w_in_sweep & ~done);

        case (r_state)
            S_IDLE: begin
                w_addr_nxt = '0;
                if (done) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 2'd0;
                end
            end

            S_WAIT: begin
                if (r_wait_cnt == c_LAT) begin
                    w_out_data_nxt  = bus.reg_data;
                    w_out_last_nxt  = (r_addr == c_LAST_ADDR);
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_OUT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                end
            end

            S_OUT: begin
                // Address only moves on the handshake so the core sees a
                // stable address for the whole WAIT/OUT span of one word.
                if (w_handshake) begin
                    w_out_valid_nxt = 1'b0;
                    if (r_out_last) begin
                        w_addr_nxt        = '0;
                        w_frame_count_nxt = r_frame_count + COUNT_W'(1);
                        w_state_nxt       = S_FINISH;
                    end else begin
                        w_addr_nxt     = r_addr + ADDR_W'(1);
                        w_wait_cnt_nxt = 2'd0;
                        w_state_nxt    = S_WAIT;
                    end
                end
            end

            S_FINISH: begin
                // Hold here until done drops so one done level yields one frame.
                if (!done) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 2'd0;
            r_addr        <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_frame_count <= '0;
            r_err_lost    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_addr        <= w_addr_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_last    <= w_out_last_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_err_lost    <= w_err_lost_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.reg_addr  = r_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign busy          = (r_state != S_IDLE);
    assign frame_count   = r_frame_count;
    assign err_lost      = r_err_lost;

endmodule
`default_nettype wire

// File: tb/tb_fourier_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fourier_result_reader
// Purpose  : Self-checking bench. Three reader instances with different
//            NUM_WORDS / READ_LATENCY / COUNT_W share done, ready and reset.
//            A frame-level reference model predicts every output each cycle;
//            a scenario table adds end-of-scenario frame/error expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_fourier_result_reader;

    localparam int N_INST  = 3;
    localparam int M_IDLE  = 0;
    localparam int M_SWEEP = 1;
    localparam int M_FIN   = 2;
    localparam int BOUND   = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        done;
    logic        ready;
    logic [15:0] salt;
    int          mode;      // 0 ready high, 1 one-of-three, 2 random, 3 low

    // Per-instance DUT observation points
    logic [31:0] w_addr  [N_INST];
    logic [31:0] w_data  [N_INST];
    logic        w_valid [N_INST];
    logic        w_last  [N_INST];
    logic        w_busy  [N_INST];
    logic        w_err   [N_INST];
    logic [15:0] w_fc    [N_INST];

    // Core result word for an address: 0x100+addr, scrambled per frame by salt
    function automatic logic [31:0] core_word(input logic [31:0] a, input logic [15:0] s);
        return {s, 16'h0000} ^ (32'h0000_0100 + a);
    endfunction

    function automatic int cfg_nw(input int i);
        case (i)
            0:       return 16;
            1:       return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_rl(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_cw(input int i);
        return (i == 2) ? 2 : 16;
    endfunction

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        localparam int NW = (g == 0) ? 16 : ((g == 1) ? 5 : 1);
        localparam int RL = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int CW = (g == 2) ? 2 : 16;

        fourier_result_reader_if #(.DATA_W(32), .ADDR_W(32)) u_if ();

        logic          w_busy_l;
        logic          w_err_l;
        logic [CW-1:0] w_fc_l;

        fourier_result_reader #(
            .DATA_W      (32),
            .ADDR_W      (32),
            .NUM_WORDS   (NW),
            .READ_LATENCY(RL),
            .COUNT_W     (CW)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .done       (done),
            .bus        (u_if.master),
            .busy       (w_busy_l),
            .frame_count(w_fc_l),
            .err_lost   (w_err_l)
        );

        // Core read port model: data for an address appears RL cycles later
        if (RL == 0) begin : g_comb
            assign u_if.reg_data = core_word(u_if.reg_addr, salt);
        end else begin : g_pipe
            logic [31:0] r_pipe [0:RL-1];
            always @(posedge clk) begin
                r_pipe[0] <= core_word(u_if.reg_addr, salt);
                for (int k = 1; k < RL; k++) r_pipe[k] <= r_pipe[k-1];
            end
            assign u_if.reg_data = r_pipe[RL-1];
        end

        assign u_if.out_ready = ready;
        assign w_addr[g]  = u_if.reg_addr;
        assign w_data[g]  = u_if.out_data;
        assign w_valid[g] = u_if.out_valid;
        assign w_last[g]  = u_if.out_last;
        assign w_busy[g]  = w_busy_l;
        assign w_err[g]   = w_err_l;
        assign w_fc[g]    = 16'(w_fc_l);
    end

    // ------------------------------------------------------------------------
    // Scoreboard counters and reference model state
    // ------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs0      = 0;        // handshakes seen on instance 0 this scenario
    int ph   [N_INST];
    int idx  [N_INST];
    int vat  [N_INST];       // cycle at which the pending word becomes valid
    int fcm  [N_INST];
    bit errm [N_INST];
    logic [15:0] fc_start [N_INST];

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d actual=0x%08h required=0x%08h", nm, inst, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d actual=timeout required=completion within %0d cycles", nm, cyc, BOUND);
    endtask

    // Compare every instance against the frame model, then advance the model
    // by the upcoming rising edge using the inputs currently applied.
    task automatic model_cycle();
        logic ev;
        cyc++;
        for (int i = 0; i < N_INST; i++) begin
            if (!reset) begin
                chk("rst_addr",  i, w_addr[i], 32'd0);
                chk("rst_data",  i, w_data[i], 32'd0);
                chk("rst_valid", i, 32'(w_valid[i]), 32'd0);
                chk("rst_last",  i, 32'(w_last[i]),  32'd0);
                chk("rst_busy",  i, 32'(w_busy[i]),  32'd0);
                chk("rst_fc",    i, 32'(w_fc[i]),    32'd0);
                chk("rst_err",   i, 32'(w_err[i]),   32'd0);
                ph[i]   = M_IDLE;
                idx[i]  = 0;
                fcm[i]  = 0;
                errm[i] = 1'b0;
            end else begin
                ev = (ph[i] == M_SWEEP) && (cyc >= vat[i]);
                chk("out_valid",   i, 32'(w_valid[i]), 32'(ev));
                chk("reg_addr",    i, w_addr[i], 32'(idx[i]));
                chk("busy",        i, 32'(w_busy[i]), 32'(ph[i] != M_IDLE));
                chk("frame_count", i, 32'(w_fc[i]), 32'(fcm[i]));
                chk("err_lost",    i, 32'(w_err[i]), 32'(errm[i]));
                if (ev) begin
                    chk("out_data", i, w_data[i], core_word(32'(idx[i]), salt));
                    chk("out_last", i, 32'(w_last[i]), 32'(idx[i] == cfg_nw(i) - 1));
                end
                if (i == 0 && ev && ready) hs0++;
                case (ph[i])
                    M_IDLE: begin
                        if (done) begin
                            ph[i]  = M_SWEEP;
                            vat[i] = cyc + cfg_rl(i) + 2;
                        end
                    end
                    M_SWEEP: begin
                        if (!done) errm[i] = 1'b1;
                        if (ev && ready) begin
                            idx[i]++;
                            if (idx[i] == cfg_nw(i)) begin
                                idx[i] = 0;
                                fcm[i] = (fcm[i] + 1) % (1 << cfg_cw(i));
                                ph[i]  = M_FIN;
                            end else begin
                                vat[i] = cyc + cfg_rl(i) + 2;
                            end
                        end
                    end
                    default: begin
                        if (!done) ph[i] = M_IDLE;
                    end
                endcase
            end
        end
    endtask

    // One clock: check at the falling edge, then drive ready just after the rising edge
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        case (mode)
            0:       ready = 1'b1;
            1:       ready = (cyc % 3 == 0);
            2:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    endtask

    function automatic bit all_advanced();
        for (int i = 0; i < N_INST; i++) if (w_fc[i] == fc_start[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit any_busy();
        for (int i = 0; i < N_INST; i++) if (w_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] pick_fc(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return (i == 0) ? a : ((i == 1) ? b : c);
    endfunction

    typedef struct {
        int          ready_mode;
        int          drop_word;   // -1: hold done until every instance finishes
        logic [15:0] fc0;
        logic [15:0] fc1;
        logic [15:0] fc2;
        logic [2:0]  err;         // bit i = expected err_lost of instance i
    } scen_t;

    scen_t tbl [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=hung required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b0;
        done  = 1'b0;
        ready = 1'b0;
        salt  = 16'h0000;
        mode  = 3;
        for (int i = 0; i < N_INST; i++) begin
            ph[i] = M_IDLE; idx[i] = 0; vat[i] = 0; fcm[i] = 0; errm[i] = 1'b0;
        end

        // Frames per scenario; instance 2 has a 2-bit counter (1,2,3,0,1)
        tbl[0] = '{0, -1, 16'd1, 16'd1, 16'd1, 3'b000};   // basic frame, data 0x100+addr
        tbl[1] = '{1, -1, 16'd2, 16'd2, 16'd2, 3'b000};   // ready 1-of-3
        tbl[2] = '{2, -1, 16'd3, 16'd3, 16'd3, 3'b000};   // random ready
        tbl[3] = '{0,  5, 16'd4, 16'd4, 16'd0, 3'b011};   // done lost at word 5
        tbl[4] = '{2, -1, 16'd5, 16'd5, 16'd1, 3'b011};   // clean frame, flag sticky

        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();

        for (int s = 0; s < 5; s++) begin
            mode = tbl[s].ready_mode;
            hs0  = 0;
            for (int i = 0; i < N_INST; i++) fc_start[i] = w_fc[i];
            done  = 1'b1;
            guard = 0;
            if (tbl[s].drop_word < 0) begin
                while (!all_advanced() && guard < BOUND) begin step(); guard++; end
            end else begin
                while (hs0 < tbl[s].drop_word && guard < BOUND) begin step(); guard++; end
            end
            if (guard >= BOUND) timeout_fail("frame_wait");
            done  = 1'b0;
            guard = 0;
            while (any_busy() && guard < BOUND) begin step(); guard++; end
            if (guard >= BOUND) timeout_fail("idle_wait");
            for (int i = 0; i < N_INST; i++) begin
                chk("tbl_frame_count", i, 32'(w_fc[i]),
                    32'(pick_fc(i, tbl[s].fc0, tbl[s].fc1, tbl[s].fc2)));
                chk("tbl_err_lost", i, 32'(w_err[i]), 32'(tbl[s].err[i]));
            end
            salt = 16'($urandom);
            repeat (4 + $urandom_range(0, 3)) step();
        end

        // Asynchronous reset while instance 0 is stalled on word 7
        mode  = 0;
        hs0   = 0;
        done  = 1'b1;
        guard = 0;
        while (hs0 < 7 && guard < BOUND) begin step(); guard++; end
        if (guard >= BOUND) timeout_fail("word7_wait");
        mode  = 3;
        ready = 1'b0;
        step();
        step();
        chk("stall_valid", 0, 32'(w_valid[0]), 32'd1);
        chk("stall_addr",  0, w_addr[0], 32'd7);
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < N_INST; i++) begin
            chk("async_addr",  i, w_addr[i], 32'd0);
            chk("async_data",  i, w_data[i], 32'd0);
            chk("async_valid", i, 32'(w_valid[i]), 32'd0);
            chk("async_last",  i, 32'(w_last[i]),  32'd0);
            chk("async_busy",  i, 32'(w_busy[i]),  32'd0);
            chk("async_fc",    i, 32'(w_fc[i]),    32'd0);
            chk("async_err",   i, 32'(w_err[i]),   32'd0);
        end
        done = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        salt  = 16'($urandom);
        repeat (5) step();

        // A new done restarts cleanly from address 0
        mode = 0;
        for (int i = 0; i < N_INST; i++) fc_start[i] = w_fc[i];
        done  = 1'b1;
        guard = 0;
        while (!all_advanced() && guard < BOUND) begin step(); guard++; end
        if (guard >= BOUND) timeout_fail("restart_wait");
        done  = 1'b0;
        guard = 0;
        while (any_busy() && guard < BOUND) begin step(); guard++; end
        if (guard >= BOUND) timeout_fail("restart_idle");
        for (int i = 0; i < N_INST; i++) begin
            chk("restart_fc",  i, 32'(w_fc[i]),  32'd1);
            chk("restart_err", i, 32'(w_err[i]), 32'd0);
        end
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
